// File: rtl/l1_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : l1_burst_arbiter                                                  |
// | Brief  : Round-robin arbiter sharing one L1 memory port among cache-side   |
// |          requesters, with in-order read-burst tracking and return routing. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module l1_burst_arbiter #(
   parameter int NUM_REQ         = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_request,
   input  logic [NUM_REQ*32-1:0]  req_addr,
   input  logic [NUM_REQ*32-1:0]  req_data,
   input  logic [NUM_REQ-1:0]     req_rnw,
   input  logic [NUM_REQ*4-1:0]   req_be,
   input  logic [NUM_REQ*5-1:0]   req_size,
   input  logic [NUM_REQ-1:0]     req_is_amo,
   input  logic [NUM_REQ*5-1:0]   req_amo,
   output logic [NUM_REQ-1:0]     req_ack,
   output logic                   mem_request,
   output logic [31:0]            mem_addr,
   output logic [31:0]            mem_data,
   output logic                   mem_rnw,
   output logic [3:0]             mem_be,
   output logic [4:0]             mem_size,
   output logic                   mem_is_amo,
   output logic [4:0]             mem_amo,
   input  logic                   mem_ack,
   input  logic                   mem_rd_data_valid,
   input  logic [31:0]            mem_rd_data,
   output logic [NUM_REQ-1:0]     rsp_data_valid,
   output logic [31:0]            rsp_data
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t            r_state, w_state_nxt;
   logic [ID_W-1:0]   r_grant, r_rr_ptr;
   logic [ID_W-1:0]   w_sel, w_g, w_ptr_nxt;
   logic [ID_W:0]     w_dist, w_best;
   logic              w_any, w_mem_req, w_fire, w_full, w_push, w_pop, w_beat;
   logic [NUM_REQ-1:0] w_elig;

   // Tracking FIFO: one entry per outstanding read burst
   logic [ID_W-1:0]   r_fifo_id   [MAX_OUTSTANDING];
   logic [4:0]        r_fifo_size [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic [4:0]        r_word_cnt;

   // Per-requester request fields, unpacked for indexing by grant
   logic [31:0] w_addr_a [NUM_REQ];
   logic [31:0] w_data_a [NUM_REQ];
   logic [3:0]  w_be_a   [NUM_REQ];
   logic [4:0]  w_size_a [NUM_REQ];
   logic [4:0]  w_amo_a  [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_addr_a[i] = req_addr[32*i +: 32];
      assign w_data_a[i] = req_data[32*i +: 32];
      assign w_be_a[i]   = req_be[4*i +: 4];
      assign w_size_a[i] = req_size[5*i +: 5];
      assign w_amo_a[i]  = req_amo[5*i +: 5];
   end

   // Full uses the registered count, so a same-cycle pop never unblocks a read
   assign w_full = (r_count == FULL_CNT);
   assign w_elig = req_request & ~(req_rnw & {NUM_REQ{w_full}});

   // Round-robin pick: eligible requester with the smallest distance from rr_ptr
   always_comb begin
      w_any  = 1'b0;
      w_sel  = '0;
      w_dist = '0;
      w_best = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_elig[j]) begin
            w_dist = (ID_W+1)'(j)
                   + ((ID_W'(j) < r_rr_ptr) ? (ID_W+1)'(NUM_REQ) : '0)
                   - {1'b0, r_rr_ptr};
            if (!w_any || (w_dist < w_best)) begin
               w_best = w_dist;
               w_sel  = ID_W'(j);
               w_any  = 1'b1;
            end
         end
      end
   end

   // Next-state and grant source: live selection in IDLE, frozen grant in LOCKED
   always_comb begin
      w_state_nxt = r_state;
      w_g         = w_sel;
      w_mem_req   = 1'b0;
      case (r_state)
         IDLE: begin
            w_g       = w_sel;
            w_mem_req = w_any;
            if (w_any && !mem_ack) w_state_nxt = LOCKED;
         end
         LOCKED: begin
            w_g       = r_grant;
            w_mem_req = 1'b1;
            if (mem_ack) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign mem_request = w_mem_req & ~rst;
   assign w_fire      = mem_request & mem_ack;
   assign req_ack     = w_fire ? (NUM_REQ'(1) << w_g) : '0;
   assign w_ptr_nxt   = (w_g == ID_W'(NUM_REQ - 1)) ? '0 : w_g + 1'b1;

   assign mem_addr   = w_addr_a[w_g];
   assign mem_data   = w_data_a[w_g];
   assign mem_rnw    = req_rnw[w_g];
   assign mem_be     = w_be_a[w_g];
   assign mem_size   = w_size_a[w_g];
   assign mem_is_amo = req_is_amo[w_g];
   assign mem_amo    = w_amo_a[w_g];

   // Arbitration state: FSM, frozen grant and round-robin pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_any && !mem_ack) r_grant <= w_sel;
         if (w_fire) r_rr_ptr <= w_ptr_nxt;
      end
   end

   // Read-return routing follows the head of the tracking FIFO
   assign w_push         = w_fire & mem_rnw;
   assign w_beat         = mem_rd_data_valid & (r_count != '0) & ~rst;
   assign w_pop          = w_beat & (r_word_cnt == r_fifo_size[r_rd_ptr]);
   assign rsp_data_valid = w_beat ? (NUM_REQ'(1) << r_fifo_id[r_rd_ptr]) : '0;
   assign rsp_data       = mem_rd_data;

   // FIFO pointers, occupancy and per-burst word counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_word_cnt <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         if (w_beat) r_word_cnt <= w_pop ? 5'd0 : r_word_cnt + 5'd1;
      end
   end

   // FIFO payload storage; contents are meaningful only below the count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_id[r_wr_ptr]   <= w_g;
         r_fifo_size[r_wr_ptr] <= w_size_a[w_g];
      end
   end

   // A returned word with nothing outstanding indicates a memory-side protocol error
   a_no_orphan_beat: assert property (@(posedge clk) disable iff (rst)
      !(mem_rd_data_valid && (r_count == '0)));

endmodule
`default_nettype wire
